// File: rtl/imem_readback_tx_pkg.sv
// Shared definitions for the instruction-memory readback transmitter and the loader.
// Holds the default widths, the frame length, the FSM state type and the mode encodings.
package imem_readback_tx_pkg;

  localparam int ADR_W       = 10;
  localparam int DATA_W      = 40;
  localparam int BYTE_W      = 8;
  localparam int FRAME_BYTES = 7;

  localparam logic [1:0] MODE_DEBUG   = 2'd0;
  localparam logic [1:0] MODE_MEMLOAD = 2'd1;
  localparam logic [1:0] MODE_RUN     = 2'd3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    CAPT = 3'd2,
    SEND = 3'd3,
    FIN  = 3'd4
  } state_e;

endpackage

// File: rtl/imem_readback_tx_sync_edge.sv
// Two-flop synchroniser for an asynchronous level, followed by a rising-edge detector.
// The edge tracker runs every cycle so a level that is already high never produces an edge.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic rise_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Next values of the synchroniser chain and the edge tracker
  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Synchroniser and edge-tracker flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_out = sync_q & ~prev_q;

endmodule

// File: rtl/imem_readback_tx.sv
// Dumps a range of instruction memory to the host as 7-byte {address, data} frames,
// one byte per host acknowledge, in the same byte order the loader shifter consumes.
module imem_readback_tx #(
  parameter int ADR_W  = imem_readback_tx_pkg::ADR_W,
  parameter int DATA_W = imem_readback_tx_pkg::DATA_W,
  parameter int BYTE_W = imem_readback_tx_pkg::BYTE_W
) (
  input  logic              clk_int,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADR_W-1:0]  start_adr,
  input  logic [ADR_W:0]    word_count,
  output logic              imem_read_en,
  output logic [ADR_W-1:0]  imem_read_adr,
  input  logic [DATA_W-1:0] imem_out,
  input  logic              host_ack,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  output logic [2:0]        byte_idx,
  output logic              busy,
  output logic              done
);

  import imem_readback_tx_pkg::*;

  localparam int         FRAME_W  = FRAME_BYTES * BYTE_W;
  localparam int         PAD_W    = FRAME_W - ADR_W - DATA_W;
  localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

  state_e              state_q, state_d;
  logic [ADR_W-1:0]    cur_adr_q, cur_adr_d;
  logic [ADR_W:0]      remaining_q, remaining_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic [2:0]          byte_idx_q, byte_idx_d;
  logic [BYTE_W-1:0]   byte_out_q, byte_out_d;
  logic                ack_evt;

  sync_edge u_sync_edge (
    .clk      (clk_int),
    .rst_n    (reset),
    .d_in     (host_ack),
    .rise_out (ack_evt)
  );

  // Next-state and datapath updates; abort outranks every other request
  always_comb begin
    state_d     = state_q;
    cur_adr_d   = cur_adr_q;
    remaining_d = remaining_q;
    frame_d     = frame_q;
    byte_idx_d  = byte_idx_q;
    byte_out_d  = byte_out_q;
    case (state_q)
      IDLE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (start) begin
          if (word_count != '0) begin
            cur_adr_d   = start_adr;
            remaining_d = word_count;
            state_d     = READ;
          end else begin
            state_d = FIN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          state_d = CAPT;
        end
      end
      CAPT: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          frame_d    = {{PAD_W{1'b0}}, cur_adr_q, imem_out};
          byte_idx_d = 3'd0;
          byte_out_d = frame_d[FRAME_W-1 -: BYTE_W];
          state_d    = SEND;
        end
      end
      SEND: begin
        if (abort) begin
          state_d = IDLE;
        end else if (ack_evt) begin
          if (byte_idx_q != LAST_IDX) begin
            frame_d    = frame_q << BYTE_W;
            byte_idx_d = byte_idx_q + 3'd1;
            byte_out_d = frame_d[FRAME_W-1 -: BYTE_W];
            state_d    = SEND;
          end else begin
            remaining_d = remaining_q - {{ADR_W{1'b0}}, 1'b1};
            cur_adr_d   = cur_adr_q + {{(ADR_W-1){1'b0}}, 1'b1};
            if (remaining_d == '0) begin
              state_d = FIN;
            end else begin
              state_d = READ;
            end
          end
        end else begin
          state_d = SEND;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_int or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cur_adr_q   <= '0;
      remaining_q <= '0;
      frame_q     <= '0;
      byte_idx_q  <= 3'd0;
      byte_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_adr_q   <= cur_adr_d;
      remaining_q <= remaining_d;
      frame_q     <= frame_d;
      byte_idx_q  <= byte_idx_d;
      byte_out_q  <= byte_out_d;
    end
  end

  // Outputs decode straight from flops, so they are glitch-free
  assign imem_read_en  = (state_q == READ);
  assign imem_read_adr = cur_adr_q;
  assign byte_valid    = (state_q == SEND);
  assign byte_out      = byte_out_q;
  assign byte_idx      = byte_idx_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == FIN);

endmodule
